// File: rtl/snake_pkg.sv
// Shared types for the snake game controller:
// FSM states, move directions and key event bundle.
package snake_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef struct packed {
    logic esc;
    logic pause;
    logic resume;
    logic start;
    logic right;
    logic left;
    logic down;
    logic up;
  } keys_t;

  // UP<->DOWN and LEFT<->RIGHT differ only in bit 0
  function automatic dir_t opposite(dir_t d);
    return dir_t'({d[1], ~d[0]});
  endfunction

endpackage

// File: rtl/key_edge_sync.sv
// Two-flop synchronizer plus rising-edge detect
// for the eight asynchronous key levels.
module key_edge_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] keys,
  output logic [7:0] pulse
);

  logic [7:0] s1;
  logic [7:0] s2;
  logic [7:0] s3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= keys;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/snake_control.sv
// Snake game state machine: key events, move tick,
// segment shift register and wall/self collision.
module snake_control
  import snake_pkg::*;
#(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int LEN      = 5,
  parameter int TICK_DIV = 12_500_000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           up,
  input  logic                           down,
  input  logic                           left,
  input  logic                           right,
  input  logic                           start,
  input  logic                           resume,
  input  logic                           pause,
  input  logic                           escape,
  output logic [1:0]                     state,
  output logic [LEN*$clog2(GRID_W)-1:0]  seg_x,
  output logic [LEN*$clog2(GRID_H)-1:0]  seg_y,
  output logic                           step,
  output logic                           game_over
);

  localparam int X_W = $clog2(GRID_W);
  localparam int Y_W = $clog2(GRID_H);
  localparam int CW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [7:0]     ev;
  keys_t          k;
  state_t         st;
  state_t         st_nx;
  dir_t           dir_cur;
  dir_t           dir_next;
  dir_t           dir_ev;
  logic           dir_vld;
  logic           accept;
  logic           ctl;
  logic           init;
  logic           wrap;
  logic           off;
  logic           hit;
  logic           move;
  logic           die;
  logic [CW-1:0]  cnt;
  logic [X_W-1:0] sx [LEN];
  logic [Y_W-1:0] sy [LEN];
  logic [X_W-1:0] hx;
  logic [Y_W-1:0] hy;

  key_edge_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .keys  ({escape, pause, resume, start,
             right, left, down, up}),
    .pulse (ev)
  );

  assign k    = keys_t'(ev);
  assign ctl  = k.esc | k.pause | k.resume | k.start;
  assign init = k.esc |
                (k.start & (st == IDLE || st == OVER));
  assign wrap = (st == RUN) &&
                (cnt == CW'(TICK_DIV - 1));
  assign move = wrap & ~k.esc & ~k.pause & ~(off | hit);
  assign die  = wrap & ~k.esc & ~k.pause & (off | hit);

  always_comb begin
    dir_vld = 1'b1;
    dir_ev  = RIGHT;
    if (k.up)         dir_ev = UP;
    else if (k.down)  dir_ev = DOWN;
    else if (k.left)  dir_ev = LEFT;
    else if (k.right) dir_ev = RIGHT;
    else              dir_vld = 1'b0;
  end

  // judged against the committed direction, not the queued one
  assign accept = (st == RUN) && dir_vld && !ctl &&
                  (dir_ev != opposite(dir_cur));

  always_comb begin
    hx  = sx[0];
    hy  = sy[0];
    off = 1'b0;
    unique case (dir_next)
      UP: begin
        off = (sy[0] == '0);
        hy  = sy[0] - Y_W'(1);
      end
      DOWN: begin
        off = (sy[0] == Y_W'(GRID_H - 1));
        hy  = sy[0] + Y_W'(1);
      end
      LEFT: begin
        off = (sx[0] == '0);
        hx  = sx[0] - X_W'(1);
      end
      RIGHT: begin
        off = (sx[0] == X_W'(GRID_W - 1));
        hx  = sx[0] + X_W'(1);
      end
    endcase
  end

  // tail vacates its cell on this step, so it is skipped
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < LEN - 1; i++) begin
      if (sx[i] == hx && sy[i] == hy) hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE: begin
        if (k.start) st_nx = RUN;
      end
      RUN: begin
        if (k.esc)        st_nx = IDLE;
        else if (k.pause) st_nx = PAUSE;
        else if (die)     st_nx = OVER;
      end
      PAUSE: begin
        if (k.esc)         st_nx = IDLE;
        else if (k.resume) st_nx = RUN;
      end
      OVER: begin
        if (k.esc)        st_nx = IDLE;
        else if (k.start) st_nx = RUN;
      end
    endcase
  end

  always_comb begin
    state     = st;
    game_over = (st == OVER);
    seg_x     = '0;
    seg_y     = '0;
    for (int i = 0; i < LEN; i++) begin
      seg_x[i*X_W +: X_W] = sx[i];
      seg_y[i*Y_W +: Y_W] = sy[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || init) begin
      cnt      <= '0;
      dir_cur  <= RIGHT;
      dir_next <= RIGHT;
      for (int i = 0; i < LEN; i++) begin
        sx[i] <= X_W'(GRID_W / 2 - i);
        sy[i] <= Y_W'(GRID_H / 2);
      end
    end else begin
      if (st == RUN && !k.pause) begin
        cnt <= wrap ? '0 : cnt + CW'(1);
      end
      if (accept) dir_next <= dir_ev;
      if (move) begin
        dir_cur <= dir_next;
        for (int i = 1; i < LEN; i++) begin
          sx[i] <= sx[i-1];
          sy[i] <= sy[i-1];
        end
        sx[0] <= hx;
        sy[0] <= hy;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) step <= 1'b0;
    else        step <= move;
  end

endmodule

// File: tb/tb_snake_control.sv
// Directed bench for snake_control with a short
// move tick (TICK_DIV=4) on a 40x30 grid, LEN=5.
module tb_snake_control;

  localparam int K_UP     = 0;
  localparam int K_DOWN   = 1;
  localparam int K_LEFT   = 2;
  localparam int K_RIGHT  = 3;
  localparam int K_START  = 4;
  localparam int K_RESUME = 5;
  localparam int K_PAUSE  = 6;
  localparam int K_ESC    = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  keys = '0;
  logic [1:0]  state;
  logic [29:0] seg_x;
  logic [24:0] seg_y;
  logic        step;
  logic        game_over;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  snake_control #(
    .GRID_W   (40),
    .GRID_H   (30),
    .LEN      (5),
    .TICK_DIV (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .up        (keys[K_UP]),
    .down      (keys[K_DOWN]),
    .left      (keys[K_LEFT]),
    .right     (keys[K_RIGHT]),
    .start     (keys[K_START]),
    .resume    (keys[K_RESUME]),
    .pause     (keys[K_PAUSE]),
    .escape    (keys[K_ESC]),
    .state     (state),
    .seg_x     (seg_x),
    .seg_y     (seg_y),
    .step      (step),
    .game_over (game_over)
  );

  function automatic logic [10:0] seg(int i);
    return {seg_x[i*6 +: 6], seg_y[i*5 +: 5]};
  endfunction

  function automatic logic [10:0] xy(int x, int y);
    return {6'(x), 5'(y)};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // returns just after the edge where the key event acts
  task automatic press(input int b);
    keys[b] = 1'b1;
    cyc(3);
    keys[b] = 1'b0;
  endtask

  task automatic wait_step(input string tag);
    int n;
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (step !== 1'b1 && n < 16);
    total++;
    if (step !== 1'b1) begin
      bad++;
      $display("FAIL %s step_timeout got=%b want=1", tag, step);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    keys  = '0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  // start event, then up event one cycle later while in RUN
  task automatic start_up();
    keys[K_START] = 1'b1;
    cyc(1);
    keys[K_UP] = 1'b1;
    cyc(3);
    keys[K_START] = 1'b0;
    keys[K_UP] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(2);
    total++;
    if (state !== 2'd0) begin
      bad++; $display("FAIL rst_state got=%0d want=0", state);
    end
    total++;
    if (step !== 1'b0 || game_over !== 1'b0) begin
      bad++; $display("FAIL rst_flags got=%b%b want=00", step, game_over);
    end
    total++;
    if (seg(0) !== xy(20, 15) || seg(4) !== xy(16, 15)) begin
      bad++; $display("FAIL rst_segs got=%h/%h want=%h/%h",
                      seg(0), seg(4), xy(20, 15), xy(16, 15));
    end
    rst_n = 1'b1;
    cyc(1);
    total++;
    if (state !== 2'd0) begin
      bad++; $display("FAIL rst_idle got=%0d want=0", state);
    end
  endtask

  task automatic test_start();
    press(K_START);
    total++;
    if (state !== 2'd1 || step !== 1'b0) begin
      bad++; $display("FAIL start_state got=%0d/%b want=1/0", state, step);
    end
    total++;
    if (seg(0) !== xy(20, 15) || seg(4) !== xy(16, 15)) begin
      bad++; $display("FAIL start_segs got=%h/%h want=%h/%h",
                      seg(0), seg(4), xy(20, 15), xy(16, 15));
    end
    cyc(3);
    total++;
    if (step !== 1'b0) begin
      bad++; $display("FAIL start_early_step got=%b want=0", step);
    end
    cyc(1);
    total++;
    if (step !== 1'b1) begin
      bad++; $display("FAIL first_step got=%b want=1", step);
    end
    total++;
    if (seg(0) !== xy(21, 15) || seg(1) !== xy(20, 15)) begin
      bad++; $display("FAIL first_move got=%h/%h want=%h/%h",
                      seg(0), seg(1), xy(21, 15), xy(20, 15));
    end
    cyc(1);
    total++;
    if (step !== 1'b0) begin
      bad++; $display("FAIL step_width got=%b want=0", step);
    end
  endtask

  task automatic test_direction();
    wait_step("dir_sync");
    press(K_LEFT);
    wait_step("dir_left");
    total++;
    if (seg(0) !== xy(23, 15)) begin
      bad++; $display("FAIL reverse_ignored got=%h want=%h", seg(0), xy(23, 15));
    end
    press(K_UP);
    wait_step("dir_up");
    total++;
    if (seg(0) !== xy(23, 14) || seg(1) !== xy(23, 15)) begin
      bad++; $display("FAIL turn_up got=%h/%h want=%h/%h",
                      seg(0), seg(1), xy(23, 14), xy(23, 15));
    end
    cyc(1);
    press(K_RIGHT);
    total++;
    if (step !== 1'b1 || seg(0) !== xy(23, 13)) begin
      bad++; $display("FAIL dir_on_tick got=%b/%h want=1/%h",
                      step, seg(0), xy(23, 13));
    end
    wait_step("dir_right");
    total++;
    if (seg(0) !== xy(24, 13)) begin
      bad++; $display("FAIL dir_next_tick got=%h want=%h", seg(0), xy(24, 13));
    end
  endtask

  task automatic test_wall();
    int pulses;
    do_reset();
    start_up();
    for (int i = 0; i < 15; i++) wait_step("wall_run");
    total++;
    if (seg(0) !== xy(20, 0) || seg(4) !== xy(20, 4) || state !== 2'd1) begin
      bad++; $display("FAIL wall_reach got=%h/%h/%0d want=%h/%h/1",
                      seg(0), seg(4), state, xy(20, 0), xy(20, 4));
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (step === 1'b1) pulses++;
    end
    total++;
    if (state !== 2'd3 || game_over !== 1'b1) begin
      bad++; $display("FAIL wall_over got=%0d/%b want=3/1", state, game_over);
    end
    total++;
    if (seg(0) !== xy(20, 0) || pulses !== 0) begin
      bad++; $display("FAIL wall_frozen got=%h/%0d want=%h/0",
                      seg(0), pulses, xy(20, 0));
    end
  endtask

  task automatic test_pause();
    int pulses;
    do_reset();
    press(K_START);
    wait_step("pause_sync");
    press(K_PAUSE);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (step === 1'b1) pulses++;
    end
    total++;
    if (state !== 2'd2 || seg(0) !== xy(21, 15) || pulses !== 0) begin
      bad++; $display("FAIL pause_hold got=%0d/%h/%0d want=2/%h/0",
                      state, seg(0), pulses, xy(21, 15));
    end
    press(K_RESUME);
    total++;
    if (state !== 2'd1 || step !== 1'b0) begin
      bad++; $display("FAIL resume_state got=%0d/%b want=1/0", state, step);
    end
    cyc(1);
    total++;
    if (step !== 1'b0) begin
      bad++; $display("FAIL resume_early got=%b want=0", step);
    end
    cyc(1);
    total++;
    if (step !== 1'b1 || seg(0) !== xy(22, 15)) begin
      bad++; $display("FAIL resume_step got=%b/%h want=1/%h",
                      step, seg(0), xy(22, 15));
    end
  endtask

  task automatic test_self_hit();
    do_reset();
    start_up();
    wait_step("self_up");
    press(K_LEFT);
    wait_step("self_left");
    total++;
    if (seg(0) !== xy(19, 14) || seg(3) !== xy(19, 15)) begin
      bad++; $display("FAIL self_path got=%h/%h want=%h/%h",
                      seg(0), seg(3), xy(19, 14), xy(19, 15));
    end
    press(K_DOWN);
    cyc(1);
    total++;
    if (state !== 2'd3 || game_over !== 1'b1 || step !== 1'b0) begin
      bad++; $display("FAIL self_over got=%0d/%b/%b want=3/1/0",
                      state, game_over, step);
    end
    total++;
    if (seg(0) !== xy(19, 14)) begin
      bad++; $display("FAIL self_frozen got=%h want=%h", seg(0), xy(19, 14));
    end
    press(K_START);
    total++;
    if (state !== 2'd1 || seg(0) !== xy(20, 15) || seg(3) !== xy(17, 15)) begin
      bad++; $display("FAIL over_restart got=%0d/%h/%h want=1/%h/%h",
                      state, seg(0), seg(3), xy(20, 15), xy(17, 15));
    end
  endtask

  task automatic test_escape_reset();
    wait_step("esc_sync");
    press(K_ESC);
    total++;
    if (state !== 2'd0 || seg(0) !== xy(20, 15) || seg(4) !== xy(16, 15)) begin
      bad++; $display("FAIL escape_init got=%0d/%h/%h want=0/%h/%h",
                      state, seg(0), seg(4), xy(20, 15), xy(16, 15));
    end
    press(K_START);
    press(K_PAUSE);
    total++;
    if (state !== 2'd2 || seg(0) !== xy(20, 15) || step !== 1'b0) begin
      bad++; $display("FAIL pause_on_tick got=%0d/%h/%b want=2/%h/0",
                      state, seg(0), step, xy(20, 15));
    end
    rst_n = 1'b0;
    cyc(1);
    total++;
    if (state !== 2'd0 || game_over !== 1'b0 || step !== 1'b0) begin
      bad++; $display("FAIL rst_in_pause got=%0d/%b/%b want=0/0/0",
                      state, game_over, step);
    end
    rst_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    test_reset();
    test_start();
    test_direction();
    test_wall();
    test_pause();
    test_self_hit();
    test_escape_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
